div_unit: RTL

Multi-cycle 32-bit integer divider serving the EX stage's DIV/DIVU instructions. EX is the initiator: it issues a start request with operands and holds it. This block is the responder: it iterates one quotient bit per clock and returns a 64-bit result. EX routes the result onto its HI/LO write port (hi = remainder, lo = quotient).

---
 rtl/div_unit_pkg.sv | 43 ++++
 rtl/div_if.sv | 33 +++
 rtl/div_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared EX-stage definitions: divider states, handshake levels, ALU op codes.
// Also holds the negate/abs helpers used by the divider and signed multiply.
package div_unit_pkg;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;

   localparam logic [7:0] EXE_OP_NOP   = 8'h00;
   localparam logic [7:0] EXE_OP_MULT  = 8'h18;
   localparam logic [7:0] EXE_OP_MULTU = 8'h19;
   localparam logic [7:0] EXE_OP_DIV   = 8'h1a;
   localparam logic [7:0] EXE_OP_DIVU  = 8'h1b;
   localparam logic [7:0] EXE_OP_ADD   = 8'h20;
   localparam logic [7:0] EXE_OP_ADDU  = 8'h21;
   localparam logic [7:0] EXE_OP_SUB   = 8'h22;
   localparam logic [7:0] EXE_OP_SUBU  = 8'h23;
   localparam logic [7:0] EXE_OP_AND   = 8'h24;
   localparam logic [7:0] EXE_OP_OR    = 8'h25;
   localparam logic [7:0] EXE_OP_XOR   = 8'h26;
   localparam logic [7:0] EXE_OP_NOR   = 8'h27;
   localparam logic [7:0] EXE_OP_SLT   = 8'h2a;
   localparam logic [7:0] EXE_OP_SLTU  = 8'h2b;

   function automatic logic [31:0] neg32(input logic [31:0] a);
      return ~a + 32'd1;
   endfunction

   // |0x80000000| stays 0x80000000 as an unsigned magnitude
   function automatic logic [31:0] abs32(input logic [31:0] a,
                                         input logic       sgn);
      return (sgn && a[31]) ? neg32(a) : a;
   endfunction

endpackage

// File: rtl/div_if.sv
// EX <-> divider request/result bundle.
// EX drives the master side, the divider is the slave.
interface div_if;

   logic        div_i_signed;
   logic [31:0] div_i_opdata1;
   logic [31:0] div_i_opdata2;
   logic        div_i_start;
   logic        div_i_annul;
   logic [63:0] div_o_result;
   logic        div_o_ready;

   modport master (
      output div_i_signed,
      output div_i_opdata1,
      output div_i_opdata2,
      output div_i_start,
      output div_i_annul,
      input  div_o_result,
      input  div_o_ready
   );

   modport slave (
      input  div_i_signed,
      input  div_i_opdata1,
      input  div_i_opdata2,
      input  div_i_start,
      input  div_i_annul,
      output div_o_result,
      output div_o_ready
   );

endinterface

// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider, one quotient bit per clock.
// Result is {remainder, quotient}, valid while in DIV_END.
module div_unit
   import div_unit_pkg::*;
(
   input logic clk,
   input logic rst_,
   div_if.slave bus
);

   div_state_e  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [64:0] rq_q, rq_d;
   logic [31:0] op1_q, op1_d;
   logic [31:0] op2_q, op2_d;
   logic        sgn_q, sgn_d;
   logic        s1_q, s1_d;
   logic        s2_q, s2_d;
   logic [63:0] result_q, result_d;
   logic        ready_q, ready_d;

   logic        req;
   logic        abort;
   logic [32:0] rem_sh;
   logic [32:0] rem_sub;
   logic        q_bit;
   logic [64:0] rq_step;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;
   logic [2:0]  unused_bits;

   assign req   = (bus.div_i_start == DIV_START) && !bus.div_i_annul;
   assign abort = bus.div_i_annul || (bus.div_i_start == DIV_STOP);

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q  <= DIV_FREE;
         cnt_q    <= '0;
         rq_q     <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         sgn_q    <= 1'b0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         result_q <= '0;
         ready_q  <= DIV_RESULT_NOT_READY;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rq_q     <= rq_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         sgn_q    <= sgn_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DIV_FREE: begin
            if (req)
               state_d = (bus.div_i_opdata2 == 32'd0) ? DIV_BYZERO
                                                      : DIV_ON;
         end
         DIV_BYZERO: state_d = DIV_END;
         DIV_ON: begin
            if (abort)
               state_d = DIV_FREE;
            else if (cnt_q == 5'd31)
               state_d = DIV_END;
         end
         DIV_END: begin
            if (bus.div_i_start == DIV_STOP)
               state_d = DIV_FREE;
         end
         default: state_d = DIV_FREE;
      endcase
   end

   // Dividend bits enter from op1_q MSB first; rq_q starts cleared
   always_comb begin
      rem_sh  = {rq_q[63:32], op1_q[~cnt_q]};
      rem_sub = rem_sh - {1'b0, op2_q};
      q_bit   = (rem_sh >= {1'b0, op2_q});
      rq_step = {q_bit ? rem_sub : rem_sh, rq_q[30:0], q_bit};
      quo_fix = (sgn_q && (s1_q ^ s2_q)) ? neg32(rq_step[31:0])
                                         : rq_step[31:0];
      rem_fix = (sgn_q && s1_q) ? neg32(rq_step[63:32])
                                : rq_step[63:32];
   end

   assign unused_bits = {rq_q[64], rq_q[31], rq_step[64]};

   always_comb begin
      cnt_d    = cnt_q;
      rq_d     = rq_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      sgn_d    = sgn_q;
      s1_d     = s1_q;
      s2_d     = s2_q;
      result_d = result_q;
      unique case (state_q)
         DIV_FREE: begin
            result_d = '0;
            if (req) begin
               op1_d = abs32(bus.div_i_opdata1, bus.div_i_signed);
               op2_d = abs32(bus.div_i_opdata2, bus.div_i_signed);
               sgn_d = bus.div_i_signed;
               s1_d  = bus.div_i_opdata1[31];
               s2_d  = bus.div_i_opdata2[31];
               cnt_d = '0;
               rq_d  = '0;
            end
         end
         DIV_BYZERO: result_d = '0;
         DIV_ON: begin
            if (!abort) begin
               cnt_d = cnt_q + 5'd1;
               rq_d  = rq_step;
               if (cnt_q == 5'd31)
                  result_d = {rem_fix, quo_fix};
            end
         end
         DIV_END: begin
            if (bus.div_i_start == DIV_STOP)
               result_d = '0;
         end
         default: result_d = '0;
      endcase
      ready_d = (state_d == DIV_END) ? DIV_RESULT_READY
                                     : DIV_RESULT_NOT_READY;
   end

   assign bus.div_o_result = result_q;
   assign bus.div_o_ready  = ready_q;

endmodule
